// File: rtl/relu_pkg.sv
// Shared constants for the streaming ReLU stage: activation mode codes and FSM states.
package relu_pkg;

  // Activation selected per frame; applied identically to every lane.
  localparam logic [1:0] RELU_MODE_RELU   = 2'd0;
  localparam logic [1:0] RELU_MODE_LEAKY  = 2'd1;
  localparam logic [1:0] RELU_MODE_CLIP   = 2'd2;
  localparam logic [1:0] RELU_MODE_BYPASS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } relu_state_e;

endpackage

// File: rtl/relu_lane.sv
// Combinational activation for one signed lane. Every result fits in DATA_W:
// each mode either passes x, returns 0, returns clip_max or shrinks a negative.
module relu_lane
  import relu_pkg::*;
#(
  parameter int DATA_W     = 45,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic        [1:0]        mode,
  input  logic signed [DATA_W-1:0] clip_max,
  output logic signed [DATA_W-1:0] y
);

  logic x_neg;
  logic clip_neg;

  assign x_neg    = x[DATA_W-1];
  assign clip_neg = clip_max[DATA_W-1];

  // Select the activation; a negative clip ceiling forces the clipped output to 0.
  always_comb begin
    y = x;
    case (mode)
      RELU_MODE_RELU: begin
        if (x_neg) y = '0;
      end
      RELU_MODE_LEAKY: begin
        // Arithmetic shift floors toward -inf, so -1 stays -1.
        if (x_neg) y = x >>> LEAK_SHIFT;
      end
      RELU_MODE_CLIP: begin
        if (x_neg || clip_neg) y = '0;
        else if (x > clip_max) y = clip_max;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/relu_stream.sv
// Streaming ReLU stage: frame FSM, pixel counter, single output register with
// valid/ready handshake, and CHANNELS parallel activation lanes.
module relu_stream
  import relu_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int DATA_W     = 45,
  parameter int FRAME_X    = 24,
  parameter int FRAME_Y    = 24,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       relu_enable,
  input  logic [1:0]                 mode,
  input  logic [DATA_W-1:0]          clip_max,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_last,
  output logic                       relu_done,
  output logic                       busy
);

  localparam int FRAME_PIX = FRAME_X * FRAME_Y;
  localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

  relu_state_e state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] clip_q;
  logic [CNT_W-1:0]  pix_cnt;
  // Set once the final pixel has been accepted; closes the input side.
  logic              in_done;

  logic [CHANNELS-1:0][DATA_W-1:0] lane_x;
  logic [CHANNELS-1:0][DATA_W-1:0] lane_y;

  logic in_hs;
  logic out_hs;
  logic beat_last;

  // Packed lane c sits at [c*DATA_W +: DATA_W], same as the flat bus.
  assign lane_x = in_data;

  // The register can take a new beat when empty or draining this cycle.
  assign in_ready  = (state_q == ST_RUN) && !in_done && (!out_valid || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign beat_last = (pix_cnt == LAST_PIX);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    relu_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x       (lane_x[g]),
      .mode    (mode_q),
      .clip_max(clip_q),
      .y       (lane_y[g])
    );
  end

  // Frame FSM: latch config at start, count accepted beats, pulse done after the last output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= RELU_MODE_RELU;
      clip_q    <= '0;
      pix_cnt   <= '0;
      in_done   <= 1'b0;
      relu_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          relu_done <= 1'b0;
          if (relu_enable) begin
            mode_q  <= mode;
            clip_q  <= clip_max;
            pix_cnt <= '0;
            in_done <= 1'b0;
            busy    <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_hs) begin
            if (beat_last) in_done <= 1'b1;
            else           pix_cnt <= pix_cnt + 1'b1;
          end
          if (out_hs && out_last) begin
            relu_done <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          relu_done <= 1'b0;
          busy      <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          relu_done <= 1'b0;
          busy      <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: reload on accept (covers drain+refill in one cycle), else empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_data  <= lane_y;
      out_last  <= beat_last;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_stream.sv
// Directed bench for relu_stream: table of per-frame lane vectors with hand-computed
// results, plus random-handshake frames, a mid-frame reset and a mode-switch frame.
module tb_relu_stream;

  localparam int CH = 8;
  localparam int DW = 45;
  localparam int FX = 24;
  localparam int FY = 24;
  localparam int LS = 3;
  localparam int N  = FX * FY;
  localparam int W  = CH * DW;

  localparam longint MAXP = (64'sd1 <<< 44) - 64'sd1;
  localparam longint MINN = -(64'sd1 <<< 44);

  logic          clk = 1'b0;
  logic          rst;
  logic          relu_enable;
  logic [1:0]    mode;
  logic [DW-1:0] clip_max;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          relu_done;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]    md;
    logic [DW-1:0] clip;
    logic [W-1:0]  xa;   // lanes for the first half of the frame
    logic [W-1:0]  xb;   // lanes for the second half
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
  } vec_t;

  vec_t tbl[8];

  relu_stream #(
    .CHANNELS(CH), .DATA_W(DW), .FRAME_X(FX), .FRAME_Y(FY), .LEAK_SHIFT(LS)
  ) dut (
    .clk(clk), .rst(rst), .relu_enable(relu_enable), .mode(mode), .clip_max(clip_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .relu_done(relu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Four lane values repeated across all eight lanes.
  function automatic logic [W-1:0] lanes4(input longint a, input longint b,
                                          input longint c, input longint d);
    logic [W-1:0]  v;
    logic [63:0]   t;
    longint        s[4];
    s = '{a, b, c, d};
    v = '0;
    for (int i = 0; i < CH; i++) begin
      t = s[i % 4];
      v[i*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] v;
    logic [63:0]  r;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      r = {$urandom, $urandom};
      v[i*DW +: DW] = r[DW-1:0];
    end
    return v;
  endfunction

  // Reference activation used only for randomly generated data.
  function automatic logic [W-1:0] model(input logic [1:0] md, input logic [DW-1:0] clip,
                                         input logic [W-1:0] v);
    logic [W-1:0]         r;
    logic signed [DW-1:0] x, c, y;
    r = '0;
    c = clip;
    for (int i = 0; i < CH; i++) begin
      x = v[i*DW +: DW];
      case (md)
        2'd0:    y = (x < 0) ? '0 : x;
        2'd1:    y = (x < 0) ? (x >>> LS) : x;
        2'd2:    y = (x < 0 || c < 0) ? '0 : ((x > c) ? c : x);
        default: y = x;
      endcase
      r[i*DW +: DW] = y;
    end
    return r;
  endfunction

  // Runs one frame from IDLE; starts and ends at a negedge.
  task automatic run_frame(input string tag, input vec_t v, input bit rnd_data,
                           input bit rnd_hs, input bit wiggle, input int abort_at);
    logic [W-1:0] expq[$];
    logic [W-1:0] x, held;
    int  acc = 0, outs = 0, done_cnt = 0, inv_err = 0, cyc = 0;
    int  last_cyc = -1, done_cyc = -1, tail = 0;
    bit  stall, ih, oh;
    x = '0;
    mode = v.md; clip_max = v.clip; relu_enable = 1'b1;
    @(posedge clk); #1;
    relu_enable = 1'b0;
    chk({tag, " busy_start"}, W'(busy), W'(1));
    @(negedge clk);
    while (cyc < 8000) begin
      if (acc < N) begin
        x = rnd_data ? rand_beat() : ((acc < N/2) ? v.xa : v.xb);
        in_data  = x;
        in_valid = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wiggle) begin
        relu_enable = (acc == 50);
        if (acc >= 100) begin mode = 2'd0; clip_max = DW'(3); end
      end
      #1;
      ih = in_valid && in_ready;
      oh = out_valid && out_ready;
      if (acc < N && in_ready !== (!out_valid || out_ready)) inv_err++;
      if (acc >= N && in_ready !== 1'b0) inv_err++;
      if (oh) begin
        if (expq.size() == 0) chk({tag, " extra_beat"}, W'(outs), W'(N));
        else chk({tag, " data"}, out_data, expq.pop_front());
        chk({tag, " last"}, W'(out_last), W'(outs == N-1));
        outs++;
        if (out_last) last_cyc = cyc;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (ih) begin
        expq.push_back(rnd_data ? model(v.md, v.clip, x) : ((acc < N/2) ? v.ea : v.eb));
        acc++;
      end
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " rst_valid"}, W'(out_valid), W'(0));
        chk({tag, " rst_ready"}, W'(in_ready), W'(0));
        chk({tag, " rst_busy"},  W'(busy), W'(0));
        chk({tag, " rst_done"},  W'(relu_done), W'(0));
        rst = 1'b0; relu_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          if (relu_done) done_cnt++;
        end
        chk({tag, " no_done_after_rst"}, W'(done_cnt), W'(0));
        @(negedge clk);
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (relu_done) begin done_cnt++; done_cyc = cyc; end
      if (stall) begin
        chk({tag, " hold_valid"}, W'(out_valid), W'(1));
        chk({tag, " hold_data"}, out_data, held);
      end
      if (last_cyc >= 0) tail++;
      if (tail == 3) break;
      @(negedge clk);
    end
    in_valid = 1'b0; relu_enable = 1'b0;
    chk({tag, " finished_in_budget"}, W'(last_cyc >= 0), W'(1));
    chk({tag, " accepted"}, W'(acc), W'(N));
    chk({tag, " emitted"}, W'(outs), W'(N));
    chk({tag, " done_count"}, W'(done_cnt), W'(1));
    chk({tag, " done_timing"}, W'(done_cyc), W'(last_cyc + 1));
    chk({tag, " ready_rule"}, W'(inv_err), W'(0));
    chk({tag, " idle_busy"}, W'(busy), W'(0));
    @(negedge clk);
  endtask

  initial begin
    vec_t r;
    rst = 1'b1; relu_enable = 1'b0; mode = 2'd0; clip_max = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset out_data",  out_data, '0);
    chk("reset out_last",  W'(out_last), W'(0));
    chk("reset relu_done", W'(relu_done), W'(0));
    chk("reset busy",      W'(busy), W'(0));
    chk("reset in_ready",  W'(in_ready), W'(0));
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = '{2'd0, '0, lanes4(64'h1fedcba98765, 64'h1fedcba98765, 64'h1fedcba98765, 64'h1fedcba98765),
               lanes4(64'h0fedcba98765, 64'h0fedcba98765, 64'h0fedcba98765, 64'h0fedcba98765), '0,
               lanes4(64'h0fedcba98765, 64'h0fedcba98765, 64'h0fedcba98765, 64'h0fedcba98765)};
    tbl[1] = '{2'd1, '0, lanes4(-16, -1, -8, 100), lanes4(-16, -1, -8, 100),
               lanes4(-2, -1, -1, 100), lanes4(-2, -1, -1, 100)};
    tbl[2] = '{2'd2, DW'(6), lanes4(-5, 3, 6, 7), lanes4(-5, 3, 6, 7),
               lanes4(0, 3, 6, 6), lanes4(0, 3, 6, 6)};
    tbl[3] = '{2'd2, {DW{1'b1}}, lanes4(-5, 3, 6, 7), lanes4(MAXP, 1, 0, 100), '0, '0};
    tbl[4] = '{2'd1, '0, lanes4(-7, MINN, 0, MAXP), lanes4(-9, -64, 7, 8),
               lanes4(-1, -(64'sd1 <<< 41), 0, MAXP), lanes4(-2, -8, 7, 8)};
    tbl[5] = '{2'd3, '0, lanes4(-5, MINN, 12345, 7), lanes4(-1, MAXP, -100, 0),
               lanes4(-5, MINN, 12345, 7), lanes4(-1, MAXP, -100, 0)};
    tbl[6] = '{2'd0, '0, lanes4(-1, 0, 1, MAXP), lanes4(MINN, 2, -3, 4),
               lanes4(0, 0, 1, MAXP), lanes4(0, 2, 0, 4)};
    tbl[7] = '{2'd2, DW'(MAXP), lanes4(-1, 0, MAXP, 5), lanes4(MINN, 9, 10, 11),
               lanes4(0, 0, MAXP, 5), lanes4(0, 9, 10, 11)};

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), tbl[i], 1'b0, 1'(i % 2), (i == 5), -1);

    // Clip ceiling 0: every lane collapses to 0.
    r = '{2'd2, '0, lanes4(5, 0, -3, 1), lanes4(MAXP, 1, 2, 3), '0, '0};
    run_frame("clip0", r, 1'b0, 1'b0, 1'b0, -1);

    r = '{2'd1, '0, '0, '0, '0, '0};
    run_frame("rand_leaky", r, 1'b1, 1'b1, 1'b0, -1);
    r.md = 2'd2; r.clip = DW'(64'sd1 <<< 43);
    run_frame("rand_clip", r, 1'b1, 1'b1, 1'b0, -1);

    run_frame("abort", tbl[0], 1'b0, 1'b1, 1'b0, 100);
    run_frame("post_abort", tbl[0], 1'b0, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
